sram_req_arbiter: RTL

//  Shares one SRAM-like memory port between the fetch stage (inst side) and the memory stage (data side).

---
 rtl/sram_req_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sram_req_arbiter.sv
// Shares one split-transaction SRAM port between fetch (inst) and load/store (data); data has priority with anti-starvation for inst.
// 0-cycle arbitration in IDLE; responses routed combinationally from an in-order outstanding FIFO; mem_req drops while the FIFO is full.
module sram_req_arbiter #(
   parameter int OST_DEPTH  = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_cancel,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        proto_err
);
   localparam int PW = $clog2(OST_DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [PW:0]   FIFO_LIM   = (PW+1)'(OST_DEPTH);

   typedef enum logic [1:0] {IDLE, G_INST, G_DATA} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] starve_cnt;
   logic          own_data [OST_DEPTH];
   logic          discard  [OST_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          sel_inst, sel_data, fifo_full, fifo_empty, hs, push, pop;

   assign fifo_full  = (count == FIFO_LIM);
   assign fifo_empty = (count == '0);

   always_comb begin
      sel_inst = 1'b0;
      sel_data = 1'b0;
      state_d  = state_q;
      case (state_q)
         IDLE: begin
            if (data_req && !(inst_req && starve_cnt == STARVE_LIM)) sel_data = 1'b1;
            else if (inst_req && !inst_cancel)                      sel_inst = 1'b1;
         end
         G_INST:  sel_inst = 1'b1;
         G_DATA:  sel_data = 1'b1;
         default: ;
      endcase
      mem_req   = ((sel_inst && inst_req) || (sel_data && data_req)) && !fifo_full;
      mem_wr    = sel_data && data_wr;
      mem_wstrb = sel_data ? data_wstrb : 4'b0000;
      mem_addr  = sel_data ? data_addr  : inst_addr;
      mem_wdata = sel_data ? data_wdata : 32'h0;
      hs        = mem_req && mem_addr_ok;
      // Grant persists until handshake; a withdrawn request or a flush releases it.
      if (hs)            state_d = IDLE;
      else if (sel_data) state_d = data_req ? G_DATA : IDLE;
      else if (sel_inst) state_d = (inst_req && !inst_cancel) ? G_INST : IDLE;
   end

   assign inst_addr_ok = hs && sel_inst;
   assign data_addr_ok = hs && sel_data;
   assign push = hs;
   assign pop  = mem_data_ok && !fifo_empty;

   assign inst_data_ok = pop && !own_data[rd_ptr] && !discard[rd_ptr];
   assign data_data_ok = pop && own_data[rd_ptr];
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         starve_cnt <= '0;
         proto_err  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (!inst_req || inst_addr_ok)            starve_cnt <= '0;
         else if (sel_data && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
         if (mem_data_ok && fifo_empty) proto_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < OST_DEPTH; i++) begin
            own_data[i] <= 1'b0;
            discard[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < OST_DEPTH; i++)
            if (inst_cancel && !own_data[i]) discard[i] <= 1'b1;
         if (pop) begin
            discard[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         // A fetch accepted in the same cycle as a flush is born discarded.
         if (push) begin
            own_data[wr_ptr] <= sel_data;
            discard[wr_ptr]  <= sel_inst && inst_cancel;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule
